// File: rtl/fetch_pc_gen_pkg.sv
// rtl/fetch_pc_gen_pkg.sv - shared types and helpers for the fetch-stage PC generator
package fetch_pc_gen_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
        logic  pred;
        word_t target;
    } fetch_out_t;

    localparam word_t PC_ALIGN_MASK = 32'hFFFF_FFFC;

    // Instruction addresses are word aligned; low two bits are always dropped.
    function automatic word_t align_pc(input word_t pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// rtl/fetch_pc_gen_if.sv - predictor, redirect, imem and decode signals of the PC generator
interface fetch_pc_gen_if;
    import fetch_pc_gen_pkg::*;

    // branch prediction table / BTB lookup
    word_t pc_fetch;
    logic  pred_fetch;
    logic  btb_hit;
    word_t btb_target;

    // redirect from branch resolution
    logic  redirect_en;
    word_t redirect_pc;

    // instruction memory read
    logic  imem_ren;
    word_t imem_addr;
    logic  imem_ready;
    word_t imem_rdata;

    // fetch -> decode
    logic  fd_valid;
    logic  fd_ready;
    word_t fd_instr;
    word_t fd_pc;
    logic  fd_pred;
    word_t fd_target;

    modport master (
        output pc_fetch, imem_ren, imem_addr,
        output fd_valid, fd_instr, fd_pc, fd_pred, fd_target,
        input  pred_fetch, btb_hit, btb_target,
        input  redirect_en, redirect_pc,
        input  imem_ready, imem_rdata, fd_ready
    );

    modport slave (
        input  pc_fetch, imem_ren, imem_addr,
        input  fd_valid, fd_instr, fd_pc, fd_pred, fd_target,
        output pred_fetch, btb_hit, btb_target,
        output redirect_en, redirect_pc,
        output imem_ready, imem_rdata, fd_ready
    );

endinterface

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - fetch PC generator: one outstanding imem read, 1-entry decode buffer
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter word_t       RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_INC   = 4
) (
    input  logic           CLK,
    input  logic           nRST,
    fetch_pc_gen_if.master bus
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    logic         pred_q, pred_d;
    word_t        nxt_q, nxt_d;
    word_t        redir_q, redir_d;
    logic         fd_valid_q, fd_valid_d;
    fetch_out_t   fd_q, fd_d;

    logic  buf_free;
    logic  pred_now;
    word_t seq_pc;
    word_t nxt_now;
    word_t redirect_al;

    logic  ren;
    logic  load;
    logic  load_pred;
    word_t load_nxt;

    assign buf_free    = !fd_valid_q || bus.fd_ready;
    assign seq_pc      = pc_q + PC_INC[31:0];
    assign pred_now    = bus.pred_fetch && bus.btb_hit;
    assign nxt_now     = pred_now ? align_pc(bus.btb_target) : seq_pc;
    assign redirect_al = align_pc(bus.redirect_pc);

    // FSM state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave RUN only on a stalled issue; a redirect while stalled parks in DROP
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (ren && !bus.imem_ready) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.imem_ready) begin
                    state_d = RUN;
                end else if (bus.redirect_en) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (bus.imem_ready) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // FSM outputs: read strobe, buffer load and where its prediction comes from
    always_comb begin
        ren       = 1'b0;
        load      = 1'b0;
        load_pred = pred_now;
        load_nxt  = nxt_now;
        if (nRST) begin
            case (state_q)
                RUN: begin
                    ren  = buf_free && !bus.redirect_en;
                    load = ren && bus.imem_ready;
                end
                BUSY: begin
                    ren       = 1'b1;
                    load      = bus.imem_ready && !bus.redirect_en;
                    load_pred = pred_q;
                    load_nxt  = nxt_q;
                end
                DROP: begin
                    ren = 1'b1;
                end
                default: begin
                    ren = 1'b0;
                end
            endcase
        end
    end

    // PC, latched prediction and pending redirect target; redirect always wins
    always_comb begin
        pc_d    = pc_q;
        pred_d  = pred_q;
        nxt_d   = nxt_q;
        redir_d = redir_q;
        case (state_q)
            RUN: begin
                if (bus.redirect_en) begin
                    pc_d = redirect_al;
                end else if (ren) begin
                    if (bus.imem_ready) begin
                        pc_d = nxt_now;
                    end else begin
                        pred_d = pred_now;
                        nxt_d  = nxt_now;
                    end
                end
            end
            BUSY: begin
                if (bus.imem_ready) begin
                    pc_d = bus.redirect_en ? redirect_al : nxt_q;
                end else if (bus.redirect_en) begin
                    redir_d = redirect_al;
                end
            end
            DROP: begin
                if (bus.imem_ready) begin
                    pc_d = bus.redirect_en ? redirect_al : redir_q;
                end else if (bus.redirect_en) begin
                    redir_d = redirect_al;
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // PC datapath registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q    <= RESET_PC;
            pred_q  <= 1'b0;
            nxt_q   <= '0;
            redir_q <= '0;
        end else begin
            pc_q    <= pc_d;
            pred_q  <= pred_d;
            nxt_q   <= nxt_d;
            redir_q <= redir_d;
        end
    end

    // Output buffer next state: flush on redirect, fill on a completed read, drain on transfer
    always_comb begin
        fd_valid_d = fd_valid_q;
        fd_d       = fd_q;
        if (bus.redirect_en) begin
            fd_valid_d = 1'b0;
        end else if (load) begin
            fd_valid_d = 1'b1;
            fd_d       = '{instr: bus.imem_rdata, pc: pc_q, pred: load_pred, target: load_nxt};
        end else if (bus.fd_ready) begin
            fd_valid_d = 1'b0;
        end
    end

    // Output buffer registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fd_valid_q <= 1'b0;
            fd_q       <= '0;
        end else begin
            fd_valid_q <= fd_valid_d;
            fd_q       <= fd_d;
        end
    end

    assign bus.pc_fetch  = pc_q;
    assign bus.imem_ren  = ren;
    assign bus.imem_addr = pc_q;
    assign bus.fd_valid  = fd_valid_q;
    assign bus.fd_instr  = fd_q.instr;
    assign bus.fd_pc     = fd_q.pc;
    assign bus.fd_pred   = fd_q.pred;
    assign bus.fd_target = fd_q.target;

endmodule
